// File: rtl/fpu_seq_core.sv
// Sequential single-issue float unit: int-to-float, add and mul in one EXEC cycle,
// restoring divide at one quotient bit per cycle. Truncating, no denormals.
module fpu_seq_core #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic [1:0]                 opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       div_by_zero
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int EW    = EXP_W + 2;
    localparam int R     = MAN_W + 2;
    localparam int P     = 2 * (MAN_W + 1);
    localparam int LZ_W  = $clog2(W + 1);
    localparam int CNT_W = $clog2(MAN_W + 2);

    localparam logic signed [EW-1:0] E_BIAS  = EW'(BIAS);
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO  = EW'(0);
    localparam logic signed [EW-1:0] E_MAX   = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] E_TOP   = EW'(W - 1);
    localparam logic signed [EW-1:0] E_SHLIM = EW'(MAN_W + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_W + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_I2F = 2'b00, OP_ADD = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

    function automatic logic [LZ_W-1:0] lzc(input logic [W-1:0] v);
        logic found;
        lzc   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      lzc   = lzc + LZ_W'(1);
            end
        end
    endfunction

    function automatic logic [MAN_W:0] mant_of(input logic [W-1:0] x);
        mant_of = (x[W-2:MAN_W] != '0) ? {1'b1, x[MAN_W-1:0]} : '0;
    endfunction

    function automatic logic signed [EW-1:0] exp_of(input logic [W-1:0] x);
        exp_of = $signed({2'b00, x[W-2:MAN_W]});
    endfunction

    // Exponent is kept wide and signed so out-of-range values saturate or flush instead of wrapping.
    function automatic logic [W-1:0] pack(input logic s, input logic signed [EW-1:0] e,
                                          input logic [MAN_W-1:0] m);
        if (e >= E_MAX)       pack = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= E_ZERO) pack = {s, {(W-1){1'b0}}};
        else                  pack = {s, e[EXP_W-1:0], m};
    endfunction

    state_t           state_q;
    op_t              op_q;
    logic [W-1:0]     a_q, b_q, result_q;
    logic             dbz_q;
    logic [R-1:0]     rem_q;
    logic [R-2:0]     quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic                    sa, sb;
    logic signed [EW-1:0]    ea, eb;
    logic [MAN_W:0]          ma, mb;
    logic                    a_big, s_big;
    logic signed [EW-1:0]    e_big, e_sml, shamt, e_add;
    logic [MAN_W:0]          m_big, m_sml, m_aln;
    logic [R-1:0]            sum, sum_nrm;
    logic [LZ_W-1:0]         sum_lz;
    logic [W-1:0]            add_res;
    logic [P-1:0]            prod;
    logic signed [EW-1:0]    e_mul;
    logic [W-1:0]            mul_res;
    logic [W-1:0]            i_mag, i_nrm, i2f_res;
    logic [LZ_W-1:0]         i_lz;
    logic signed [EW-1:0]    e_i2f, e_div;
    logic                    div_ge;
    logic [R-1:0]            rem_sub, rem_nxt;
    logic [R-1:0]            quo_fin;
    logic [W-1:0]            div_res, fast_res;

    // NOTE: every signal here is assigned on every pass through the block, so no latch can be inferred.
    always_comb begin
        sa = a_q[W-1];
        sb = b_q[W-1];
        ea = exp_of(a_q);
        eb = exp_of(b_q);
        ma = mant_of(a_q);
        mb = mant_of(b_q);

        // Add: order by magnitude so the subtraction never goes negative.
        a_big   = {a_q[W-2:MAN_W], ma} >= {b_q[W-2:MAN_W], mb};
        s_big   = a_big ? sa : sb;
        e_big   = a_big ? ea : eb;
        e_sml   = a_big ? eb : ea;
        m_big   = a_big ? ma : mb;
        m_sml   = a_big ? mb : ma;
        shamt   = e_big - e_sml;
        m_aln   = (shamt >= E_SHLIM) ? '0 : (m_sml >> shamt);
        sum     = (sa == sb) ? ({1'b0, m_big} + {1'b0, m_aln}) : ({1'b0, m_big} - {1'b0, m_aln});
        sum_lz  = lzc({sum, {(W-R){1'b0}}});
        sum_nrm = sum << sum_lz;
        e_add   = e_big + E_ONE - $signed(EW'(sum_lz));
        add_res = (sum == '0) ? '0 : pack(s_big, e_add, MAN_W'(sum_nrm >> 1));

        prod    = P'(ma) * P'(mb);
        e_mul   = prod[P-1] ? (ea + eb - E_BIAS + E_ONE) : (ea + eb - E_BIAS);
        mul_res = (ma == '0 || mb == '0) ? {sa ^ sb, {(W-1){1'b0}}}
                : pack(sa ^ sb, e_mul, prod[P-1] ? MAN_W'(prod >> (MAN_W + 1)) : MAN_W'(prod >> MAN_W));

        // Two's-complement negate of the most negative value leaves 2^(W-1), the correct magnitude.
        i_mag   = a_q[W-1] ? (~a_q + W'(1)) : a_q;
        i_lz    = lzc(i_mag);
        i_nrm   = i_mag << i_lz;
        e_i2f   = E_BIAS + E_TOP - $signed(EW'(i_lz));
        i2f_res = (a_q == '0) ? '0 : pack(a_q[W-1], e_i2f, MAN_W'(i_nrm >> (W - 1 - MAN_W)));

        div_ge  = rem_q >= {1'b0, mb};
        rem_sub = div_ge ? (rem_q - {1'b0, mb}) : rem_q;
        rem_nxt = rem_sub << 1;
        quo_fin = {quo_q, div_ge};
        e_div   = ea - eb + E_BIAS;
        if (mb == '0)            div_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (ma == '0)       div_res = '0;
        else if (quo_fin[R-1])   div_res = pack(sa ^ sb, e_div, MAN_W'(quo_fin >> 1));
        else                     div_res = pack(sa ^ sb, e_div - E_ONE, MAN_W'(quo_fin));

        case (op_q)
            OP_I2F:  fast_res = i2f_res;
            OP_ADD:  fast_res = add_res;
            OP_MUL:  fast_res = mul_res;
            default: fast_res = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state here is plain flops, so clearing it in reset is cheap and makes restart deterministic.
            state_q  <= IDLE;
            op_q     <= OP_I2F;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op_t'(opcode);
                    rem_q   <= {1'b0, mant_of(a)};
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= EXEC;
                end
                EXEC: if (op_q == OP_DIV) begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_fin[R-2:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q <= div_res;
                        dbz_q    <= (mb == '0);
                        state_q  <= DONE;
                    end
                end else begin
                    result_q <= fast_res;
                    dbz_q    <= 1'b0;
                    state_q  <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpu_seq_core.sv
// Scoreboard bench for fpu_seq_core: directed vectors push expectations at accept,
// a negedge monitor pops and compares on every result handshake.
module tb_fpu_seq_core;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int FAST  = 1;
    localparam int SLOW  = MAN_W + 2;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic [1:0]   opcode = 2'b00;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] result;

    fpu_seq_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] va, vb, er;
        logic         ed;
        int           lat;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0, n_pass = 0;
    int   last_hs = -1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_dbz"}, W'(div_by_zero), W'(e.dbz));
                if (e.lat >= 0) check({e.name, "_latency"}, W'(cyc - e.acc), W'(e.lat));
            end
            last_hs = cyc + 1;
        end
    end

    task automatic issue(input vec_t v, input bit push, output int acc);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check({v.name, "_in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        a        = v.va;
        b        = v.vb;
        opcode   = v.op;
        @(posedge clk); #1;
        acc      = cyc;
        // Scramble inputs after accept; the core must ignore them until IDLE.
        in_valid = 1'b0;
        a        = ~v.va;
        b        = ~v.vb;
        opcode   = ~v.op;
        if (push) sb_q.push_back('{v.name, v.er, v.ed, v.lat, acc});
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while ((sb_q.size() != 0 || !in_ready) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_drained"}, W'(sb_q.size()), W'(0));
    endtask

    vec_t vecs [15];

    initial begin
        int  acc, rel;
        bit  seen;
        vec_t v;

        vecs = '{
            '{"add_1_2",    2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, FAST},
            '{"add_cancel", 2'b01, 32'h40400000, 32'hC0400000, 32'h00000000, 1'b0, FAST},
            '{"add_3_m1",   2'b01, 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, FAST},
            '{"add_far",    2'b01, 32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, FAST},
            '{"mul_3_2",    2'b10, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, FAST},
            '{"mul_ovf",    2'b10, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, FAST},
            '{"mul_zero",   2'b10, 32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, FAST},
            '{"mul_unf",    2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, FAST},
            '{"div_6_2",    2'b11, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, SLOW},
            '{"div_1_3",    2'b11, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, SLOW},
            '{"div_by0",    2'b11, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, SLOW},
            '{"i2f_m5",     2'b00, 32'hFFFFFFFB, 32'h12345678, 32'hC0A00000, 1'b0, FAST},
            '{"i2f_min",    2'b00, 32'h80000000, 32'h00000000, 32'hCF000000, 1'b0, FAST},
            '{"i2f_one",    2'b00, 32'h00000001, 32'h00000000, 32'h3F800000, 1'b0, FAST},
            '{"i2f_zero",   2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, FAST}
        };

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  W'(in_ready),    W'(1));
        check("rst_out_valid", W'(out_valid),   W'(0));
        check("rst_result",    result,          W'(0));
        check("rst_dbz",       W'(div_by_zero), W'(0));
        rst_n = 1'b1;
        rel   = cyc;

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1, acc);
            if (i == 0) check("first_accept_edge", W'(acc), W'(rel + 1));
        end
        drain("vectors");

        // Consumer back-pressure: result must hold and no new accept while DONE.
        v = '{"mul_2_2_stall", 2'b10, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, -1};
        issue(v, 1'b1, acc);
        out_ready = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_result",    result,        32'h40800000);
            check("stall_in_ready",  W'(in_ready),  W'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        v = '{"add_after_stall", 2'b01, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, FAST};
        issue(v, 1'b1, acc);
        check("accept_after_handshake", W'(acc), W'(last_hs + 1));
        drain("stall");

        // Reset pulse in the middle of a divide must abort it.
        v = '{"div_aborted", 2'b11, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, SLOW};
        issue(v, 1'b0, acc);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", W'(out_valid),   W'(0));
        check("abort_in_ready",  W'(in_ready),    W'(1));
        check("abort_result",    result,          W'(0));
        check("abort_dbz",       W'(div_by_zero), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", W'(seen), W'(0));
        v = '{"add_after_abort", 2'b01, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, FAST};
        issue(v, 1'b1, acc);
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
